// File: rtl/csr_regbank_pkg.sv
// csr_regbank_pkg: address-map helpers and byte-lane merge shared by the CSR bank
package csr_regbank_pkg;

    localparam int MAX_DW = 256;

    function automatic int IRQ_STATUS_ADDR(input int num_ctrl, input int num_stat);
        return num_ctrl + num_stat;
    endfunction

    function automatic int IRQ_ENABLE_ADDR(input int num_ctrl, input int num_stat);
        return num_ctrl + num_stat + 1;
    endfunction

    function automatic logic [MAX_DW-1:0] be_merge(
        input logic [MAX_DW-1:0]   old_v,
        input logic [MAX_DW-1:0]   new_v,
        input logic [MAX_DW/8-1:0] be
    );
        logic [MAX_DW-1:0] r;
        for (int i = 0; i < MAX_DW/8; i++)
            r[i*8 +: 8] = be[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        return r;
    endfunction

endpackage

// File: rtl/csr_irq_ctrl.sv
// csr_irq_ctrl: W1C interrupt status with enable mask and registered irq level
module csr_irq_ctrl #(
    parameter int IRQ_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IRQ_WIDTH-1:0] irq_event,
    input  logic                 sts_clr,
    input  logic                 en_we,
    input  logic [IRQ_WIDTH-1:0] wdata,
    input  logic [IRQ_WIDTH-1:0] wmask,
    output logic [IRQ_WIDTH-1:0] irq_status,
    output logic [IRQ_WIDTH-1:0] irq_enable,
    output logic                 irq
);

    logic [IRQ_WIDTH-1:0] sts_d, sts_q, en_d, en_q;
    logic                 irq_d, irq_q;

    // events are OR'd in after the clear so a same-cycle set beats the W1C
    always_comb begin
        sts_d = (sts_q & ~(sts_clr ? (wdata & wmask) : '0)) | irq_event;
        en_d  = en_we ? ((en_q & ~wmask) | (wdata & wmask)) : en_q;
        irq_d = |(sts_q & en_q);
    end

    // interrupt state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sts_q <= '0;
            en_q  <= '0;
            irq_q <= 1'b0;
        end else begin
            sts_q <= sts_d;
            en_q  <= en_d;
            irq_q <= irq_d;
        end
    end

    assign irq_status = sts_q;
    assign irq_enable = en_q;
    assign irq        = irq_q;

endmodule

// File: rtl/csr_regbank_avms.sv
// csr_regbank_avms: Avalon-MM CSR bank with CTRL/STAT/IRQ registers and 1-cycle reads
module csr_regbank_avms
    import csr_regbank_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_CTRL   = 8,
    parameter int NUM_STAT   = 4,
    parameter int IRQ_WIDTH  = 8,
    parameter logic [NUM_CTRL*DATA_WIDTH-1:0] CTRL_RESET = '0
) (
    input  logic                           avms_clk,
    input  logic                           avms_reset_n,
    input  logic [ADDR_WIDTH-1:0]          avms_addr,
    input  logic [DATA_WIDTH/8-1:0]        avms_byteenable,
    input  logic                           avms_read,
    input  logic                           avms_write,
    input  logic [DATA_WIDTH-1:0]          avms_writedata,
    output logic [DATA_WIDTH-1:0]          avms_readdata,
    output logic                           avms_readdatavalid,
    output logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_out,
    output logic [NUM_CTRL-1:0]            ctrl_wr_pulse,
    input  logic [NUM_STAT*DATA_WIDTH-1:0] status_in,
    input  logic [IRQ_WIDTH-1:0]           irq_event,
    output logic                           irq
);

    localparam logic [ADDR_WIDTH-1:0] STS_A = ADDR_WIDTH'(IRQ_STATUS_ADDR(NUM_CTRL, NUM_STAT));
    localparam logic [ADDR_WIDTH-1:0] EN_A  = ADDR_WIDTH'(IRQ_ENABLE_ADDR(NUM_CTRL, NUM_STAT));

    logic [DATA_WIDTH-1:0]          ctrl_d [NUM_CTRL];
    logic [DATA_WIDTH-1:0]          ctrl_q [NUM_CTRL];
    logic [NUM_STAT*DATA_WIDTH-1:0] stat_q;
    logic [NUM_CTRL-1:0]            pulse_d, pulse_q;
    logic [DATA_WIDTH-1:0]          rd_val, rdata_d, rdata_q;
    logic                           rvalid_d, rvalid_q;
    logic [IRQ_WIDTH-1:0]           irq_wmask, irq_status, irq_enable;

    assign irq_wmask = IRQ_WIDTH'(be_merge('0, '1, (MAX_DW/8)'(avms_byteenable)));

    csr_irq_ctrl #(.IRQ_WIDTH(IRQ_WIDTH)) u_irq (
        .clk        (avms_clk),
        .rst_n      (avms_reset_n),
        .irq_event  (irq_event),
        .sts_clr    (avms_write && avms_addr == STS_A),
        .en_we      (avms_write && avms_addr == EN_A),
        .wdata      (avms_writedata[IRQ_WIDTH-1:0]),
        .wmask      (irq_wmask),
        .irq_status (irq_status),
        .irq_enable (irq_enable),
        .irq        (irq)
    );

    // CTRL byte-lane writes; the pulse fires on any accepted write, even with no lanes enabled
    always_comb begin
        for (int k = 0; k < NUM_CTRL; k++) begin
            pulse_d[k] = avms_write && avms_addr == ADDR_WIDTH'(k);
            ctrl_d[k]  = pulse_d[k] ? DATA_WIDTH'(be_merge(MAX_DW'(ctrl_q[k]), MAX_DW'(avms_writedata),
                                                           (MAX_DW/8)'(avms_byteenable)))
                                    : ctrl_q[k];
        end
    end

    // read mux works from pre-write state so a simultaneous read sees the old value
    always_comb begin
        rd_val = '0;
        for (int k = 0; k < NUM_CTRL; k++)
            if (avms_addr == ADDR_WIDTH'(k)) rd_val = ctrl_q[k];
        for (int s = 0; s < NUM_STAT; s++)
            if (avms_addr == ADDR_WIDTH'(NUM_CTRL + s)) rd_val = stat_q[s*DATA_WIDTH +: DATA_WIDTH];
        if (avms_addr == STS_A) rd_val = DATA_WIDTH'(irq_status);
        if (avms_addr == EN_A)  rd_val = DATA_WIDTH'(irq_enable);
        rdata_d  = avms_read ? rd_val : rdata_q;
        rvalid_d = avms_read;
    end

    // register storage, status sampling and the read pipeline
    always_ff @(posedge avms_clk or negedge avms_reset_n) begin
        if (!avms_reset_n) begin
            for (int k = 0; k < NUM_CTRL; k++) ctrl_q[k] <= CTRL_RESET[k*DATA_WIDTH +: DATA_WIDTH];
            stat_q   <= '0;
            pulse_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            stat_q   <= status_in;
            pulse_q  <= pulse_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_CTRL; k++) begin : g_ctrl
            assign ctrl_out[k*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[k];
        end
    endgenerate

    assign ctrl_wr_pulse      = pulse_q;
    assign avms_readdata      = rdata_q;
    assign avms_readdatavalid = rvalid_q;

endmodule
